// File: rtl/conv_18_sdiv_seq_24s_8s_if.sv
// Block-level bundle for the conv_18 sequential signed divider.
// Latency: n/a (signal bundle only).
// Backpressure: none; ap_start is only honoured while ap_idle is high.
// Ports: ap_start/din0/din1 driven by the requester (master); ap_idle/ap_done/dout/rem/ovf/dbz
// driven by the divider (slave).
interface conv_18_sdiv_seq_24s_8s_if #(
  parameter int din0_WIDTH = 24,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
);
  logic                  ap_start;
  logic                  ap_idle;
  logic                  ap_done;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic [dout_WIDTH-1:0] dout;
  logic [din1_WIDTH-1:0] rem;
  logic                  ovf;
  logic                  dbz;

  modport master (
    output ap_start, din0, din1,
    input  ap_idle, ap_done, dout, rem, ovf, dbz
  );

  modport slave (
    input  ap_start, din0, din1,
    output ap_idle, ap_done, dout, rem, ovf, dbz
  );
endinterface

// File: rtl/conv_18_sdiv_seq_24s_8s.sv
// Sequential signed divider 24s/8s -> 16s quotient + 8s remainder, C truncation, saturating.
// Latency: start sampled at cycle T -> ap_done pulse at T+26 (24 CALC cycles + FIXUP + DONE).
// Backpressure: none; ap_start ignored while busy (no queuing), results hold until next FIXUP.
// Ports: ap_clk, ap_rst (async, active-high); bus (slave modport): ap_start, din0, din1 in;
// ap_idle, ap_done, dout, rem, ovf, dbz out.
module conv_18_sdiv_seq_24s_8s #(
  parameter int din0_WIDTH = 24,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 16
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  conv_18_sdiv_seq_24s_8s_if.slave bus
);

  localparam int W0 = din0_WIDTH;
  localparam int W1 = din1_WIDTH;
  localparam int WQ = dout_WIDTH;
  localparam int CW = $clog2(W0);

  localparam logic [CW-1:0] CNT_LAST  = CW'(W0 - 1);
  // Largest quotient magnitudes representable for each sign.
  localparam logic [W0-1:0] Q_POS_LIM = {{(W0-WQ+1){1'b0}}, {(WQ-1){1'b1}}};
  localparam logic [W0-1:0] Q_NEG_LIM = {{(W0-WQ){1'b0}}, 1'b1, {(WQ-1){1'b0}}};
  localparam logic [WQ-1:0] SAT_POS   = {1'b0, {(WQ-1){1'b1}}};
  localparam logic [WQ-1:0] SAT_NEG   = {1'b1, {(WQ-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB-first while quotient bits shift in at the LSB,
  // so after W0 steps this register holds the quotient magnitude.
  logic [W0-1:0]  quo_q, quo_d;
  logic [W1-1:0]  dvs_q, dvs_d;
  // Stored remainder is always < divisor magnitude, so W1 bits suffice; the W1+1-bit
  // shifted value below is the working partial remainder.
  logic [W1-1:0]  pr_q, pr_d;
  logic           sn0_q, sn0_d;
  logic           sn1_q, sn1_d;
  logic [WQ-1:0]  dout_q, dout_d;
  logic [W1-1:0]  rem_q, rem_d;
  logic           ovf_q, ovf_d;
  logic           dbz_q, dbz_d;

  logic [W0-1:0]  din0_mag;
  logic [W1-1:0]  din1_mag;
  logic [W1:0]    pr_shift;
  logic           trial_ge;
  logic [W1-1:0]  trial_diff;
  logic           q_neg;
  logic [W1-1:0]  rmag;

  // Magnitudes; the most negative values map to 2^(W-1), which still fits unsigned.
  assign din0_mag = bus.din0[W0-1] ? (~bus.din0 + W0'(1)) : bus.din0;
  assign din1_mag = bus.din1[W1-1] ? (~bus.din1 + W1'(1)) : bus.din1;

  // Restoring step: bring in next dividend bit, subtract if it fits. Only the low W1
  // bits of the difference are kept; when trial_ge holds the result is below dvs_q.
  assign pr_shift   = {pr_q, quo_q[W0-1]};
  assign trial_ge   = (pr_shift >= {1'b0, dvs_q});
  assign trial_diff = pr_shift[W1-1:0] - dvs_q;

  assign q_neg = sn0_q ^ sn1_q;
  assign rmag  = pr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    pr_d    = pr_q;
    sn0_d   = sn0_q;
    sn1_d   = sn1_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.ap_start) begin
          quo_d   = din0_mag;
          dvs_d   = din1_mag;
          sn0_d   = bus.din0[W0-1];
          sn1_d   = bus.din1[W1-1];
          pr_d    = '0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        pr_d  = trial_ge ? trial_diff : pr_shift[W1-1:0];
        quo_d = {quo_q[W0-2:0], trial_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (dvs_q == '0) begin
          // Divide by zero: the CALC result is meaningless, report signed full scale.
          dout_d = sn0_q ? SAT_NEG : SAT_POS;
          rem_d  = '0;
          ovf_d  = 1'b0;
          dbz_d  = 1'b1;
        end else begin
          dbz_d = 1'b0;
          // Remainder follows the dividend sign (C truncation).
          rem_d = sn0_q ? (~rmag + W1'(1)) : rmag;
          if (q_neg) begin
            ovf_d  = (quo_q > Q_NEG_LIM);
            dout_d = ovf_d ? SAT_NEG : (~quo_q[WQ-1:0] + WQ'(1));
          end else begin
            ovf_d  = (quo_q > Q_POS_LIM);
            dout_d = ovf_d ? SAT_POS : quo_q[WQ-1:0];
          end
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      pr_q    <= '0;
      sn0_q   <= 1'b0;
      sn1_q   <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      pr_q    <= pr_d;
      sn0_q   <= sn0_d;
      sn1_q   <= sn1_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ap_idle = (state_q == S_IDLE);
  assign bus.ap_done = (state_q == S_DONE);
  assign bus.dout    = dout_q;
  assign bus.rem     = rem_q;
  assign bus.ovf     = ovf_q;
  assign bus.dbz     = dbz_q;

endmodule
